// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings and default widths for the memory port arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W       = 8;
  typedef enum logic [2:0] {
    ARB_IDLE   = 3'b000,
    ARB_BUSY_I = 3'b001,
    ARB_BUSY_D = 3'b010,
    ARB_DONE_I = 3'b011,
    ARB_DONE_D = 3'b100
  } arb_state_t;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: busy-cycle counter flagging the cycle on which it reaches TIMEOUT
module arb_timeout_cnt
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [CNT_W:0] LIM = (CNT_W + 1)'(TIMEOUT);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  // fires on the edge that would bring the count up to TIMEOUT
  assign expired = en && (({1'b0, cnt} + (CNT_W + 1)'(1)) == LIM);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one memory port between fetch and data requesters
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);
  arb_state_t state;
  logic last_d, in_busy, expired;
  assign in_busy = (state == ARB_BUSY_I) || (state == ARB_BUSY_D);
  arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
    .clk(CLK),
    .rst(Reset),
    .clr(!in_busy),
    .en(in_busy),
    .expired(expired)
  );
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state   <= ARB_IDLE;
      last_d  <= 1'b0;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        ARB_IDLE: begin
          err <= 1'b0;
          // on a tie, the requester not served last wins
          if (d_req && (!i_req || !last_d)) begin
            state   <= ARB_BUSY_D;
            last_d  <= 1'b1;
            m_req   <= 1'b1;
            busy    <= 1'b1;
            m_we    <= d_we;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
          end else if (i_req) begin
            state  <= ARB_BUSY_I;
            last_d <= 1'b0;
            m_req  <= 1'b1;
            busy   <= 1'b1;
            m_we   <= 1'b0;
            m_addr <= i_addr;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          if (m_ready || expired) begin
            state <= (state == ARB_BUSY_I) ? ARB_DONE_I : ARB_DONE_D;
            m_req <= 1'b0;
            err   <= !m_ready;
            if (state == ARB_BUSY_I) begin
              i_ready <= 1'b1;
              i_rdata <= m_ready ? m_rdata : '0;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= m_ready ? m_rdata : '0;
            end
          end
        end
        ARB_DONE_I, ARB_DONE_D: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, timeout and reset behaviour
module tb_mem_port_arbiter;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic        i_ready, d_ready, err, m_req, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  int compared = 0, mismatched = 0;

  mem_port_arbiter dut (
    .CLK(CLK), .Reset(Reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tie_round(input bit exp_d, input logic [31:0] data);
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h100; d_addr = 32'h200;
    tick();
    chk("tie_grant_addr", m_addr, exp_d ? 32'h200 : 32'h100);
    m_ready = 1'b1; m_rdata = data;
    tick();
    chk("tie_d_ready", {31'b0, d_ready}, {31'b0, exp_d});
    chk("tie_i_ready", {31'b0, i_ready}, {31'b0, !exp_d});
    i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
    tick();
  endtask

  initial begin
    int n, hi;
    // reset state
    tick(); tick();
    chk("rst_m_req", {31'b0, m_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_i_ready", {31'b0, i_ready}, 32'd0);
    Reset = 1'b0;
    tick();
    // simultaneous requests: D, I, D
    tie_round(1'b1, 32'hAAAA_0001);
    tie_round(1'b0, 32'h5555_0002);
    tie_round(1'b1, 32'hAAAA_0003);
    chk("tie_d_rdata", d_rdata, 32'hAAAA_0003);
    chk("tie_i_rdata", i_rdata, 32'h5555_0002);
    // single fetch, k=1
    i_req = 1'b1; i_addr = 32'h0000_0040;
    tick();
    chk("f_m_req", {31'b0, m_req}, 32'd1);
    chk("f_m_addr", m_addr, 32'h40);
    chk("f_m_we", {31'b0, m_we}, 32'd0);
    chk("f_busy", {31'b0, busy}, 32'd1);
    m_ready = 1'b1; m_rdata = 32'h2001_0005;
    tick();
    chk("f_i_ready", {31'b0, i_ready}, 32'd1);
    chk("f_i_rdata", i_rdata, 32'h2001_0005);
    chk("f_err", {31'b0, err}, 32'd0);
    chk("f_m_req_done", {31'b0, m_req}, 32'd0);
    chk("f_d_ready", {31'b0, d_ready}, 32'd0);
    i_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
    tick();
    chk("f_idle_ready", {31'b0, i_ready}, 32'd0);
    chk("f_idle_busy", {31'b0, busy}, 32'd0);
    // read timeout, memory silent
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    hi = 0;
    for (n = 0; n < 40 && !d_ready; n++) begin
      if (m_req) hi++;
      tick();
    end
    chk("to_seen_ready", {31'b0, d_ready}, 32'd1);
    chk("to_m_req_cycles", hi, 32'd16);
    chk("to_err", {31'b0, err}, 32'd1);
    chk("to_d_rdata", d_rdata, 32'd0);
    d_req = 1'b0;
    tick();
    chk("to_err_clear", {31'b0, err}, 32'd0);
    // store, k=3, also the transaction after a timeout
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
    tick();
    d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0;
    for (int c = 0; c < 3; c++) begin
      chk("st_m_req", {31'b0, m_req}, 32'd1);
      chk("st_m_we", {31'b0, m_we}, 32'd1);
      chk("st_m_addr", m_addr, 32'h10);
      chk("st_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk("st_no_ready", {31'b0, d_ready}, 32'd0);
      if (c == 2) m_ready = 1'b1;
      tick();
    end
    chk("st_d_ready", {31'b0, d_ready}, 32'd1);
    chk("st_d_rdata", d_rdata, 32'd0);
    chk("st_err", {31'b0, err}, 32'd0);
    d_req = 1'b0; d_we = 1'b0; m_ready = 1'b0;
    tick();
    // m_ready on the timeout cycle counts as success
    i_req = 1'b1; i_addr = 32'h500;
    tick();
    for (int c = 0; c < 15; c++) tick();
    chk("edge_m_req", {31'b0, m_req}, 32'd1);
    chk("edge_not_ready", {31'b0, i_ready}, 32'd0);
    m_ready = 1'b1; m_rdata = 32'h1234_5678;
    tick();
    chk("edge_i_ready", {31'b0, i_ready}, 32'd1);
    chk("edge_err", {31'b0, err}, 32'd0);
    chk("edge_i_rdata", i_rdata, 32'h1234_5678);
    i_req = 1'b0; m_ready = 1'b0; m_rdata = '0;
    tick();
    // reset during BUSY cycle 2
    i_req = 1'b1; i_addr = 32'h600;
    tick();
    tick();
    Reset = 1'b1;
    #1;
    chk("mr_m_req", {31'b0, m_req}, 32'd0);
    chk("mr_busy", {31'b0, busy}, 32'd0);
    chk("mr_m_addr", m_addr, 32'd0);
    chk("mr_i_rdata", i_rdata, 32'd0);
    i_req = 1'b0; m_ready = 1'b1; m_rdata = 32'hBAD0_BAD0;
    tick();
    Reset = 1'b0; m_ready = 1'b0; m_rdata = '0;
    hi = 0;
    for (int c = 0; c < 4; c++) begin
      if (i_ready || d_ready) hi++;
      tick();
    end
    chk("mr_no_ready", hi, 32'd0);
    // fetch after reset, k=2
    i_req = 1'b1; i_addr = 32'h700;
    tick();
    chk("ar_m_addr", m_addr, 32'h700);
    tick();
    m_ready = 1'b1; m_rdata = 32'h0BAD_F00D;
    tick();
    chk("ar_i_ready", {31'b0, i_ready}, 32'd1);
    chk("ar_i_rdata", i_rdata, 32'h0BAD_F00D);
    chk("ar_err", {31'b0, err}, 32'd0);
    i_req = 1'b0; m_ready = 1'b0;
    tick();
    chk("ar_idle", {31'b0, busy}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
